// File: rtl/modinv_helper_init_gen_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// modinv_helper_init_gen_pkg : init modes and width helper for modinv helpers
// Revision: 1.0
// ----------------------------------------------------------------------------
package modinv_helper_init_gen_pkg;

    typedef enum logic [1:0] {
        MODE_STD  = 2'd0,
        MODE_SWAP = 2'd1,
        MODE_DUAL = 2'd2,
        MODE_CLR  = 2'd3
    } init_mode_e;

    // Never returns less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/modinv_helper_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// modinv_helper_seq : busy counter, start/abort/done and read/write window decode
// Revision: 1.0
// ----------------------------------------------------------------------------
module modinv_helper_seq
    import modinv_helper_init_gen_pkg::*;
#(
    parameter int N   = 8,
    parameter int B   = 9,
    parameter int L   = 2,
    parameter int OAB = 3,
    parameter int BAB = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           abort,
    output logic           rdy,
    output logic           done,
    output logic [OAB-1:0] rd_idx,
    output logic [BAB-1:0] wr_idx,
    output logic           wr_en
);

    localparam int            CW       = clog2(L + B);
    localparam logic [CW-1:0] CNT_LAST = CW'(L + B - 1);
    localparam logic [CW-1:0] CNT_L    = CW'(L);
    localparam logic [CW-1:0] CNT_N    = CW'(N);

    if ((B < N + 1) || (L < 1)) begin : g_param_check
        $error("modinv_helper_seq: requires B >= N+1 and L >= 1");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (cnt_q == '0) begin
            if (ena && !abort) begin
                cnt_d = CW'(1);
            end
        end else if (abort) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            done_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // The write window can never start at cnt 0 because L >= 1.
    assign rdy    = (cnt_q == '0);
    assign done   = done_q;
    assign rd_idx = (cnt_q < CNT_N) ? OAB'(cnt_q) : '0;
    assign wr_en  = (cnt_q >= CNT_L);
    assign wr_idx = wr_en ? BAB'(cnt_q - CNT_L) : '0;

endmodule
`default_nettype wire

// File: rtl/modinv_helper_init_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// modinv_helper_init_gen : streams A/Q operands into the r/s/u/v working buffers
// Revision: 1.0
// ----------------------------------------------------------------------------
module modinv_helper_init_gen
    import modinv_helper_init_gen_pkg::*;
#(
    parameter int WORD_W            = 32,
    parameter int OPERAND_NUM_WORDS = 8,
    parameter int OPERAND_ADDR_BITS = 3,
    parameter int BUFFER_NUM_WORDS  = 9,
    parameter int BUFFER_ADDR_BITS  = 4,
    parameter int READ_LATENCY      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic                         abort,
    input  logic [1:0]                   mode,
    output logic                         rdy,
    output logic                         done,
    output logic [OPERAND_ADDR_BITS-1:0] a_addr,
    output logic [OPERAND_ADDR_BITS-1:0] q_addr,
    input  logic [WORD_W-1:0]            a_din,
    input  logic [WORD_W-1:0]            q_din,
    output logic [BUFFER_ADDR_BITS-1:0]  r_addr,
    output logic [BUFFER_ADDR_BITS-1:0]  s_addr,
    output logic [BUFFER_ADDR_BITS-1:0]  u_addr,
    output logic [BUFFER_ADDR_BITS-1:0]  v_addr,
    output logic                         r_wren,
    output logic                         s_wren,
    output logic                         u_wren,
    output logic                         v_wren,
    output logic [WORD_W-1:0]            r_dout,
    output logic [WORD_W-1:0]            s_dout,
    output logic [WORD_W-1:0]            u_dout,
    output logic [WORD_W-1:0]            v_dout
);

    localparam int BAB = BUFFER_ADDR_BITS;

    logic [OPERAND_ADDR_BITS-1:0] rd_idx;
    logic [BAB-1:0]               wr_idx;
    logic                         wr_en;
    logic                         start;
    init_mode_e                   mode_q, mode_d;

    modinv_helper_seq #(
        .N   (OPERAND_NUM_WORDS),
        .B   (BUFFER_NUM_WORDS),
        .L   (READ_LATENCY),
        .OAB (OPERAND_ADDR_BITS),
        .BAB (BAB)
    ) u_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .abort  (abort),
        .rdy    (rdy),
        .done   (done),
        .rd_idx (rd_idx),
        .wr_idx (wr_idx),
        .wr_en  (wr_en)
    );

    assign start = rdy && ena && !abort;

    always_comb begin
        mode_d = mode_q;
        if (start) begin
            mode_d = init_mode_e'(mode);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_STD;
        end else begin
            mode_q <= mode_d;
        end
    end

    logic              is_pad;
    logic [WORD_W-1:0] one_w;
    logic [WORD_W-1:0] a_w;
    logic [WORD_W-1:0] q_w;

    // Padding words carry no operand data, whatever the memories return.
    assign is_pad = (wr_idx >= BAB'(OPERAND_NUM_WORDS));
    assign one_w  = (wr_idx == '0) ? WORD_W'(1) : '0;
    assign a_w    = is_pad ? '0 : a_din;
    assign q_w    = is_pad ? '0 : q_din;

    always_comb begin
        r_dout = '0;
        s_dout = '0;
        u_dout = '0;
        v_dout = '0;
        case (mode_q)
            MODE_STD: begin
                s_dout = one_w;
                u_dout = q_w;
                v_dout = a_w;
            end
            MODE_SWAP: begin
                s_dout = one_w;
                u_dout = a_w;
                v_dout = q_w;
            end
            MODE_DUAL: begin
                r_dout = one_w;
                u_dout = q_w;
                v_dout = a_w;
            end
            default: begin
                r_dout = '0;
            end
        endcase
    end

    assign a_addr = rd_idx;
    assign q_addr = rd_idx;
    assign r_addr = wr_idx;
    assign s_addr = wr_idx;
    assign u_addr = wr_idx;
    assign v_addr = wr_idx;
    assign r_wren = wr_en;
    assign s_wren = wr_en;
    assign u_wren = wr_en;
    assign v_wren = wr_en;

endmodule
`default_nettype wire

// File: tb/tb_modinv_helper_init_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_modinv_helper_init_gen : directed vector bench for the modinv init helper
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_modinv_helper_init_gen;

    localparam logic [63:0] SENT = 64'hDEAD_BEEF_DEAD_BEEF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] ena;
    logic       abort;
    logic [1:0] mode;
    int         sel;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults (W=32, L=2, B=9)
    logic        d0_rdy, d0_done, d0_rw, d0_sw, d0_uw, d0_vw;
    logic [2:0]  d0_aa, d0_qa;
    logic [3:0]  d0_ra, d0_sa, d0_ua, d0_va;
    logic [31:0] d0_a, d0_q, d0_r, d0_s, d0_u, d0_v;
    // Instance 1: W=64, L=1, B=11
    logic        d1_rdy, d1_done, d1_rw, d1_sw, d1_uw, d1_vw;
    logic [2:0]  d1_aa, d1_qa;
    logic [3:0]  d1_ra, d1_sa, d1_ua, d1_va;
    logic [63:0] d1_a, d1_q, d1_r, d1_s, d1_u, d1_v;
    // Instance 2: W=64, L=4, B=11
    logic        d2_rdy, d2_done, d2_rw, d2_sw, d2_uw, d2_vw;
    logic [2:0]  d2_aa, d2_qa;
    logic [3:0]  d2_ra, d2_sa, d2_ua, d2_va;
    logic [63:0] d2_a, d2_q, d2_r, d2_s, d2_u, d2_v;

    modinv_helper_init_gen u_dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena[0]), .abort(abort), .mode(mode),
        .rdy(d0_rdy), .done(d0_done), .a_addr(d0_aa), .q_addr(d0_qa),
        .a_din(d0_a), .q_din(d0_q),
        .r_addr(d0_ra), .s_addr(d0_sa), .u_addr(d0_ua), .v_addr(d0_va),
        .r_wren(d0_rw), .s_wren(d0_sw), .u_wren(d0_uw), .v_wren(d0_vw),
        .r_dout(d0_r), .s_dout(d0_s), .u_dout(d0_u), .v_dout(d0_v)
    );

    modinv_helper_init_gen #(.WORD_W(64), .BUFFER_NUM_WORDS(11), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena[1]), .abort(abort), .mode(mode),
        .rdy(d1_rdy), .done(d1_done), .a_addr(d1_aa), .q_addr(d1_qa),
        .a_din(d1_a), .q_din(d1_q),
        .r_addr(d1_ra), .s_addr(d1_sa), .u_addr(d1_ua), .v_addr(d1_va),
        .r_wren(d1_rw), .s_wren(d1_sw), .u_wren(d1_uw), .v_wren(d1_vw),
        .r_dout(d1_r), .s_dout(d1_s), .u_dout(d1_u), .v_dout(d1_v)
    );

    modinv_helper_init_gen #(.WORD_W(64), .BUFFER_NUM_WORDS(11), .READ_LATENCY(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena[2]), .abort(abort), .mode(mode),
        .rdy(d2_rdy), .done(d2_done), .a_addr(d2_aa), .q_addr(d2_qa),
        .a_din(d2_a), .q_din(d2_q),
        .r_addr(d2_ra), .s_addr(d2_sa), .u_addr(d2_ua), .v_addr(d2_va),
        .r_wren(d2_rw), .s_wren(d2_sw), .u_wren(d2_uw), .v_wren(d2_vw),
        .r_dout(d2_r), .s_dout(d2_s), .u_dout(d2_u), .v_dout(d2_v)
    );

    // Operand memories: A[j]=j+1, Q[j]=0xFFFF_FFFF-j (32-bit); tagged words for 64-bit
    function automatic logic [31:0] a32(input logic [2:0] j);
        return 32'(j) + 32'd1;
    endfunction
    function automatic logic [31:0] q32(input logic [2:0] j);
        return 32'hFFFF_FFFF - 32'(j);
    endfunction
    function automatic logic [63:0] a64(input logic [2:0] j);
        return {32'h1234_5678, 29'd0, j};
    endfunction
    function automatic logic [63:0] q64(input logic [2:0] j);
        return {32'hFEDC_BA98, 29'd0, j};
    endfunction

    logic [2:0] p0 [4];
    logic [2:0] p1 [4];
    logic [2:0] p2 [4];

    always @(posedge clk) begin
        p0[0] <= d0_aa; p0[1] <= p0[0]; p0[2] <= p0[1]; p0[3] <= p0[2];
        p1[0] <= d1_aa; p1[1] <= p1[0]; p1[2] <= p1[1]; p1[3] <= p1[2];
        p2[0] <= d2_aa; p2[1] <= p2[0]; p2[2] <= p2[1]; p2[3] <= p2[2];
    end

    assign d0_a = a32(p0[1]);
    assign d0_q = q32(p0[1]);
    assign d1_a = a64(p1[0]);
    assign d1_q = q64(p1[0]);
    assign d2_a = a64(p2[3]);
    assign d2_q = q64(p2[3]);

    // Observation view of the selected instance
    logic        o_rdy, o_done, o_wren, o_cons;
    logic [2:0]  o_aa;
    logic [3:0]  o_addr;
    logic [63:0] o_r, o_s, o_u, o_v;

    always_comb begin
        o_rdy = d0_rdy; o_done = d0_done; o_wren = d0_rw; o_aa = d0_aa; o_addr = d0_ra;
        o_r = 64'(d0_r); o_s = 64'(d0_s); o_u = 64'(d0_u); o_v = 64'(d0_v);
        o_cons = (d0_qa == d0_aa) && (d0_sa == d0_ra) && (d0_ua == d0_ra) && (d0_va == d0_ra)
                 && (d0_sw == d0_rw) && (d0_uw == d0_rw) && (d0_vw == d0_rw);
        if (sel == 1) begin
            o_rdy = d1_rdy; o_done = d1_done; o_wren = d1_rw; o_aa = d1_aa; o_addr = d1_ra;
            o_r = d1_r; o_s = d1_s; o_u = d1_u; o_v = d1_v;
            o_cons = (d1_qa == d1_aa) && (d1_sa == d1_ra) && (d1_ua == d1_ra) && (d1_va == d1_ra)
                     && (d1_sw == d1_rw) && (d1_uw == d1_rw) && (d1_vw == d1_rw);
        end else if (sel == 2) begin
            o_rdy = d2_rdy; o_done = d2_done; o_wren = d2_rw; o_aa = d2_aa; o_addr = d2_ra;
            o_r = d2_r; o_s = d2_s; o_u = d2_u; o_v = d2_v;
            o_cons = (d2_qa == d2_aa) && (d2_sa == d2_ra) && (d2_ua == d2_ra) && (d2_va == d2_ra)
                     && (d2_sw == d2_rw) && (d2_uw == d2_rw) && (d2_vw == d2_rw);
        end
    end

    logic [63:0] cap_r [16];
    logic [63:0] cap_s [16];
    logic [63:0] cap_u [16];
    logic [63:0] cap_v [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction on instance s; cycle t=0 is the start cycle.
    task automatic run(input int s, input int lat, input int bw, input logic [1:0] m,
                       output int first_wr, output int nwr, output int done_t,
                       output int ndone, output int errs);
        sel = s; first_wr = -1; nwr = 0; done_t = -1; ndone = 0; errs = 0;
        for (int i = 0; i < 16; i++) begin
            cap_r[i] = SENT; cap_s[i] = SENT; cap_u[i] = SENT; cap_v[i] = SENT;
        end
        @(negedge clk);
        mode = m;
        ena[s] = 1'b1;
        for (int t = 0; t < lat + bw + 3; t++) begin
            #1;
            if (o_wren) begin
                if (nwr == 0) first_wr = t;
                nwr++;
                if (int'(o_addr) != t - lat) errs++;
                cap_r[o_addr] = o_r; cap_s[o_addr] = o_s;
                cap_u[o_addr] = o_u; cap_v[o_addr] = o_v;
            end
            if (o_cons !== 1'b1) errs++;
            if (int'(o_aa) != ((t < 8) ? t : 0)) errs++;
            if (o_done) begin
                if (ndone == 0) done_t = t;
                ndone++;
            end
            @(negedge clk);
            ena[s] = 1'b0;
        end
    endtask

    typedef struct {
        logic [1:0]  mode;
        int          word;
        logic [63:0] r, s, u, v;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int fw, nw, dt, nd, er, cnt_a, cnt_b;
        logic [63:0] u_first;

        vecs[0]  = '{2'd0, 0, 64'h0, 64'h1, 64'hFFFF_FFFF, 64'h1};
        vecs[1]  = '{2'd0, 1, 64'h0, 64'h0, 64'hFFFF_FFFE, 64'h2};
        vecs[2]  = '{2'd0, 7, 64'h0, 64'h0, 64'hFFFF_FFF8, 64'h8};
        vecs[3]  = '{2'd0, 8, 64'h0, 64'h0, 64'h0,         64'h0};
        vecs[4]  = '{2'd1, 0, 64'h0, 64'h1, 64'h1,         64'hFFFF_FFFF};
        vecs[5]  = '{2'd1, 1, 64'h0, 64'h0, 64'h2,         64'hFFFF_FFFE};
        vecs[6]  = '{2'd1, 7, 64'h0, 64'h0, 64'h8,         64'hFFFF_FFF8};
        vecs[7]  = '{2'd1, 8, 64'h0, 64'h0, 64'h0,         64'h0};
        vecs[8]  = '{2'd2, 0, 64'h1, 64'h0, 64'hFFFF_FFFF, 64'h1};
        vecs[9]  = '{2'd2, 1, 64'h0, 64'h0, 64'hFFFF_FFFE, 64'h2};
        vecs[10] = '{2'd2, 7, 64'h0, 64'h0, 64'hFFFF_FFF8, 64'h8};
        vecs[11] = '{2'd2, 8, 64'h0, 64'h0, 64'h0,         64'h0};
        vecs[12] = '{2'd3, 0, 64'h0, 64'h0, 64'h0,         64'h0};
        vecs[13] = '{2'd3, 1, 64'h0, 64'h0, 64'h0,         64'h0};
        vecs[14] = '{2'd3, 5, 64'h0, 64'h0, 64'h0,         64'h0};
        vecs[15] = '{2'd3, 8, 64'h0, 64'h0, 64'h0,         64'h0};

        rst_n = 1'b0; ena = 3'b000; abort = 1'b0; mode = 2'd0; sel = 0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_rdy", 64'(o_rdy), 64'd1);
        check("reset_wren", 64'(o_wren), 64'd0);
        check("reset_addr", 64'(o_addr), 64'd0);
        check("reset_done", 64'(o_done), 64'd0);
        check("reset_a_addr", 64'(o_aa), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Modes 0..3 with default parameters, then per-word table comparison
        for (int m = 0; m < 4; m++) begin
            run(0, 2, 9, 2'(m), fw, nw, dt, nd, er);
            check($sformatf("m%0d_first_wr", m), 64'(fw), 64'd2);
            check($sformatf("m%0d_n_writes", m), 64'(nw), 64'd9);
            check($sformatf("m%0d_done_t", m), 64'(dt), 64'd11);
            check($sformatf("m%0d_n_done", m), 64'(nd), 64'd1);
            check($sformatf("m%0d_addr_errs", m), 64'(er), 64'd0);
            for (int i = 0; i < 16; i++) begin
                if (int'(vecs[i].mode) == m) begin
                    check($sformatf("m%0d_w%0d_r", m, vecs[i].word), cap_r[vecs[i].word], vecs[i].r);
                    check($sformatf("m%0d_w%0d_s", m, vecs[i].word), cap_s[vecs[i].word], vecs[i].s);
                    check($sformatf("m%0d_w%0d_u", m, vecs[i].word), cap_u[vecs[i].word], vecs[i].u);
                    check($sformatf("m%0d_w%0d_v", m, vecs[i].word), cap_v[vecs[i].word], vecs[i].v);
                end
            end
        end

        // Parameter sweep: W=64, B=11, L=1 and L=4
        for (int k = 1; k < 3; k++) begin
            int lat;
            lat = (k == 1) ? 1 : 4;
            run(k, lat, 11, 2'd0, fw, nw, dt, nd, er);
            check($sformatf("sw%0d_first_wr", k), 64'(fw), 64'(lat));
            check($sformatf("sw%0d_n_writes", k), 64'(nw), 64'd11);
            check($sformatf("sw%0d_done_t", k), 64'(dt), 64'(lat + 11));
            check($sformatf("sw%0d_addr_errs", k), 64'(er), 64'd0);
            check($sformatf("sw%0d_u0", k), cap_u[0], 64'hFEDC_BA98_0000_0000);
            check($sformatf("sw%0d_v7", k), cap_v[7], 64'h1234_5678_0000_0007);
            check($sformatf("sw%0d_s0", k), cap_s[0], 64'h1);
            check($sformatf("sw%0d_r0", k), cap_r[0], 64'h0);
            for (int w = 8; w < 11; w++) begin
                check($sformatf("sw%0d_pad_u%0d", k, w), cap_u[w], 64'h0);
                check($sformatf("sw%0d_pad_v%0d", k, w), cap_v[w], 64'h0);
            end
        end

        // Abort at t=5
        sel = 0; cnt_a = 0; cnt_b = 0;
        @(negedge clk);
        mode = 2'd0; ena[0] = 1'b1;
        for (int t = 0; t < 16; t++) begin
            #1;
            if (t == 5) check("abort_wren_t5", 64'(o_wren), 64'd1);
            if (t == 6) begin
                check("abort_wren_t6", 64'(o_wren), 64'd0);
                check("abort_rdy_t6", 64'(o_rdy), 64'd1);
            end
            if (t >= 6 && o_wren) cnt_a++;
            if (o_done) cnt_b++;
            @(negedge clk);
            ena[0] = 1'b0;
            abort = (t == 4);
        end
        check("abort_late_writes", 64'(cnt_a), 64'd0);
        check("abort_done_pulses", 64'(cnt_b), 64'd0);

        // ena and abort together while idle: no start
        cnt_a = 0;
        ena[0] = 1'b1; abort = 1'b1;
        @(negedge clk);
        ena[0] = 1'b0; abort = 1'b0;
        for (int t = 0; t < 6; t++) begin
            #1;
            if (o_wren || !o_rdy) cnt_a++;
            @(negedge clk);
        end
        check("idle_abort_no_start", 64'(cnt_a), 64'd0);

        // Asynchronous reset during t=4
        @(negedge clk);
        mode = 2'd0; ena[0] = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            ena[0] = 1'b0;
        end
        #1;
        check("rst_pre_wren", 64'(o_wren), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_rdy", 64'(o_rdy), 64'd1);
        check("rst_mid_wren", 64'(o_wren), 64'd0);
        check("rst_mid_addr", 64'(o_addr), 64'd0);
        check("rst_mid_a_addr", 64'(o_aa), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 2, 9, 2'd0, fw, nw, dt, nd, er);
        check("rst_restart_done_t", 64'(dt), 64'd11);
        check("rst_restart_n_writes", 64'(nw), 64'd9);
        check("rst_restart_u1", cap_u[1], 64'hFFFF_FFFE);

        // ena held high: restarts at 11, 22, 33; mode changed at t=3
        cnt_a = 0; cnt_b = 0; er = 0; u_first = SENT;
        @(negedge clk);
        mode = 2'd0; ena[0] = 1'b1;
        for (int t = 0; t < 35; t++) begin
            #1;
            if (o_done) begin
                cnt_a++;
                if (t != 11 && t != 22 && t != 33) er++;
            end
            if (o_rdy) cnt_b++;
            if (t == 3) begin
                check("cont_addr_t3", 64'(o_addr), 64'd1);
                u_first = o_u;
            end
            if (t == 14) begin
                check("cont_addr_t14", 64'(o_addr), 64'd1);
                check("cont_run2_u1", o_u, 64'h0);
            end
            @(negedge clk);
            if (t == 2) mode = 2'd3;
        end
        ena[0] = 1'b0;
        check("cont_run1_u1", u_first, 64'hFFFF_FFFE);
        check("cont_done_count", 64'(cnt_a), 64'd3);
        check("cont_done_misplaced", 64'(er), 64'd0);
        check("cont_rdy_cycles", 64'(cnt_b), 64'd4);
        repeat (15) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
